lsu_ctrl: RTL
=============

// Module: lsu_ctrl
// PURPOSE
//   Load/store controller between the execute stage and data_mem.
//   Converts byte/half/word requests into word accesses on data_mem's single-word port.
//   Sub-word stores use read-modify-write; loads are extracted and sign/zero-extended.
//   Req/ready on the CPU side; single-cycle response pulse.
// PARAMETERS
//   ADDR_W  11  word-address width driven to data_mem (mem_addr = req_addr[ADDR_W+1:2])
// PORTS
//   clk           in   1       rising-edge clock
//   rst_n         in   1       synchronous active-low reset
//   req_valid     in   1       request present
//   req_ready     out  1       controller can accept (IDLE only)
//   req_we        in   1       1=store, 0=load
//   req_size      in   2       00=byte 01=half 10=word 11=reserved (treated as word)
//   req_unsigned  in   1       load zero-extends when 1, sign-extends when 0
//   req_addr      in   32      byte address
//   req_wdata     in   32      store data, right-justified
//   resp_valid    out  1       one-cycle completion pulse
//   resp_rdata    out  32      extended load data (0 for stores)
//   misalign      out  1       valid with resp_valid; request was misaligned
//   mem_write     out  1       data_mem write enable
//   mem_read      out  1       data_mem read enable
//   mem_addr      out  ADDR_W  data_mem word address
//   mem_wdata     out  32      data_mem write word
//   mem_rdata     in   32      data_mem read word (combinational read)
// BEHAVIOUR
//   Reset: state=IDLE; resp_valid=0, resp_rdata=0, misalign=0; latched request regs=0.
//   mem_write/mem_read gated by rst_n: no access in any cycle with rst_n=0.
//   Reset mid-operation aborts: no write issued, no response.
//   Accept on the rising edge with req_valid&&req_ready; request fields are latched there.
//   Inputs are ignored outside IDLE.
//   States:
//     IDLE: req_ready=1.
//       load->READ; word store->WRITE; byte/half store->RMW_RD; misaligned->RESP (see CONFIGURATION).
//     READ: mem_read=1; capture mem_rdata -> RESP.
//     RMW_RD: mem_read=1; capture mem_rdata into merge reg -> RMW_WR.
//     RMW_WR: mem_write=1; mem_wdata=merge word with target lanes replaced -> RESP.
//     WRITE: mem_write=1; mem_wdata=req_wdata -> RESP.
//     RESP: resp_valid=1 for exactly this cycle -> IDLE.
//   Latency, counted from the accept edge:
//     load, word store: resp_valid in the 2nd cycle.
//     sub-word store: resp_valid in the 3rd cycle.
//     misaligned: resp_valid in the 1st cycle.
//   Back-to-back requests: next accept no earlier than the edge that ends RESP.
//   Lanes (little-endian): byte k=addr[1:0] uses bits [8k+7:8k]; half h=addr[1] uses bits [16h+15:16h].
//   Store lanes take req_wdata[7:0] / [15:0]; untouched lanes keep the old word exactly.
//   Load extension: bit 7/15 replicated when req_unsigned=0; zeros when 1.
//   Address bits above ADDR_W+1 are ignored (wrap within data_mem).
//   mem_addr, mem_wdata hold their last values in IDLE; they are 0 after reset.
// CONFIGURATION
//   LSU_MISALIGN_TRAP_EN defined:
//     half with addr[0]=1, or word with addr[1:0]!=0 -> no memory access;
//     RESP with misalign=1, resp_rdata=0.
//   Not defined:
//     misalign tied 0; offending low bits are forced to 0;
//     the access proceeds aligned (half at addr&~1, word at addr&~3).
// TESTING
//   T1 word store 0xDEADBEEF @0x004, then word load @0x004:
//      mem_addr=1, one mem_write pulse; load resp_rdata=0xDEADBEEF 2 cycles after accept.
//   T2 word 0x11223344 @0x008, then byte store 0xAA @0x00A:
//      RMW read then write; word @0x008 becomes 0x11AA3344; resp_valid 3 cycles after accept.
//   T3 word 0x80FF7F01 @0x00C:
//      lb @0x00E -> 0xFFFFFFFF; lbu @0x00E -> 0x000000FF;
//      lh @0x00C -> 0x00007F01; lh @0x00E -> 0xFFFF80FF.
//   T4 with LSU_MISALIGN_TRAP_EN, half store @0x011:
//      no mem_write, resp_valid next cycle with misalign=1.
//      Without the macro: the store lands @0x010 lanes [15:0].
//   T5 rst_n=0 during RMW_WR cycle:
//      mem_write stays 0, memory word unchanged, next cycle IDLE with req_ready=1, resp_valid=0.
//   T6 req_valid held high across 3 loads:
//      each accepted only in IDLE; exactly 3 resp_valid pulses; no overlap.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Bundles the CPU request/response channel and the data_mem word port of lsu_ctrl.
// slave = controller side, master = CPU/memory environment side.
interface lsu_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              misalign;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, misalign,
               mem_write, mem_read, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, misalign,
               mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store controller: byte/half/word requests onto a single-word data_mem port.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word requests instead of aligning them.
module lsu_ctrl #(
    parameter int ADDR_W = 11
) (
    input logic       clk,
    input logic       rst_n,
    lsu_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RMW_RD,
        RMW_WR,
        WRITE,
        RESP
    } state_t;

    state_t            state, next_state;
    logic              uns_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;
    logic              mis_q;
    logic              accept;
    logic              is_word;
    logic              bad_align;
    logic              unused_addr_bits;

    assign accept           = bus.req_valid && (state == IDLE);
    assign is_word          = bus.req_size[1];
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad_align = is_word ? (bus.req_addr[1:0] != 2'b00)
                               : (bus.req_size[0] && bus.req_addr[0]);
`else
    assign bad_align = 1'b0;
`endif

    // Lane selection ignores addr[0] for halves, so non-trapping alignment is implicit here.
    function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [1:0] off,
                                               input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] w;
        w = old;
        if (size == 2'b00)
            w[{off, 3'b000} +: 8] = wd[7:0];
        else
            w[{off[1], 4'b0000} +: 16] = wd[15:0];
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                            input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            uns_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            addr_q      <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mis_q       <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                uns_q   <= bus.req_unsigned;
                size_q  <= bus.req_size;
                off_q   <= bus.req_addr[1:0];
                wdata_q <= bus.req_wdata;
                addr_q  <= bus.req_addr[ADDR_W+1:2];
                mis_q   <= bad_align;
                rdata_q <= '0;
                if (bus.req_we && is_word && !bad_align)
                    mem_wdata_q <= bus.req_wdata;
            end
            if (state == READ)
                rdata_q <= extract(bus.mem_rdata, off_q, size_q, uns_q);
            // The merge register doubles as the write-data register for the RMW_WR cycle.
            if (state == RMW_RD)
                mem_wdata_q <= merge_word(bus.mem_rdata, off_q, size_q, wdata_q);
            if (state == RESP)
                mis_q <= 1'b0;
        end
    end

    always_comb begin
        next_state    = state;
        bus.req_ready = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (bad_align)        next_state = RESP;
                    else if (!bus.req_we) next_state = READ;
                    else if (is_word)     next_state = WRITE;
                    else                  next_state = RMW_RD;
                end
            end
            READ: begin
                bus.mem_read = rst_n;
                next_state   = RESP;
            end
            RMW_RD: begin
                bus.mem_read = rst_n;
                next_state   = RMW_WR;
            end
            RMW_WR: begin
                bus.mem_write = rst_n;
                next_state    = RESP;
            end
            WRITE: begin
                bus.mem_write = rst_n;
                next_state    = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.resp_valid = (state == RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.misalign   = mis_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule
